// File: rtl/constraint_sweep_ctrl.sv
// Hardware sweep driver for single-output constraint evaluators: issues candidates
// by counter or LFSR, samples the latency-aligned result, counts hits, keeps the first hit.
module constraint_sweep_ctrl #(
    parameter int unsigned W         = 64,
    parameter int unsigned CW        = 32,
    parameter int unsigned LAT       = 0,
    parameter logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic          stop_on_sat_i,
    input  logic [W-1:0]  seed_i,
    input  logic [CW-1:0] max_count_i,
    output logic          cand_valid_o,
    output logic [W-1:0]  cand_data_o,
    input  logic          cand_x_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] issued_count_o,
    output logic [CW-1:0] sat_count_o,
    output logic          first_sat_found_o,
    output logic [W-1:0]  first_sat_data_o
);

    localparam int unsigned PD = (LAT == 0) ? 1 : LAT;
    localparam logic [W-1:0] TAPS = LFSR_TAPS[W-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q;
    logic          mode_q;
    logic          stop_q;
    logic [CW-1:0] max_q;
    logic          cand_valid_q;
    logic [W-1:0]  cand_data_q;
    logic [CW-1:0] issued_q;
    logic [CW-1:0] sat_q;
    logic          found_q;
    logic [W-1:0]  found_data_q;
    logic          busy_q;
    logic          done_q;

    logic [PD-1:0] tag_v_q;
    logic [W-1:0]  tag_d_q [PD];

    logic [W-1:0]  cand_next_d;
    logic [CW-1:0] issued_d;
    logic [W-1:0]  seed_eff_c;
    logic          sample_v_c;
    logic [W-1:0]  sample_d_c;
    logic          sample_hit_c;
    logic          inflight_c;

    // Next candidate: wrapping increment or right-shifting Galois LFSR.
    always_comb begin
        cand_next_d = cand_data_q + W'(1);
        if (mode_q) begin
            cand_next_d = (cand_data_q >> 1) ^ (cand_data_q[0] ? TAPS : '0);
        end
        issued_d   = issued_q + CW'(1);
        seed_eff_c = (mode_i && (seed_i == '0)) ? W'(1) : seed_i;
    end

    // Result alignment: the tag at depth LAT belongs to the cand_x seen this cycle.
    always_comb begin
        sample_v_c = cand_valid_q;
        sample_d_c = cand_data_q;
        if (LAT != 0) begin
            sample_v_c = tag_v_q[PD-1];
            sample_d_c = tag_d_q[PD-1];
        end
        sample_hit_c = sample_v_c & cand_x_i;
        inflight_c   = 1'b0;
        for (int i = 0; i + 1 < int'(LAT); i++) begin
            inflight_c = inflight_c | tag_v_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int i = 0; i < int'(PD); i++) begin
                tag_d_q[i] <= '0;
            end
        end else begin
            tag_v_q[0] <= cand_valid_q;
            tag_d_q[0] <= cand_data_q;
            for (int i = 1; i < int'(PD); i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_d_q[i] <= tag_d_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            stop_q       <= 1'b0;
            max_q        <= '0;
            cand_valid_q <= 1'b0;
            cand_data_q  <= '0;
            issued_q     <= '0;
            sat_q        <= '0;
            found_q      <= 1'b0;
            found_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Results are counted while RUN or DRAIN; only the first hit is latched.
            if (busy_q && sample_hit_c) begin
                sat_q <= sat_q + CW'(1);
                if (!found_q) begin
                    found_q      <= 1'b1;
                    found_data_q <= sample_d_c;
                end
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        mode_q       <= mode_i;
                        stop_q       <= stop_on_sat_i;
                        max_q        <= max_count_i;
                        cand_data_q  <= seed_eff_c;
                        issued_q     <= '0;
                        sat_q        <= '0;
                        found_q      <= 1'b0;
                        found_data_q <= '0;
                        if (max_count_i == '0) begin
                            state_q      <= S_DONE;
                            cand_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            state_q      <= S_RUN;
                            cand_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    issued_q    <= issued_d;
                    cand_data_q <= cand_next_d;
                    if ((issued_d == max_q) || (stop_q && sample_hit_c)) begin
                        state_q      <= S_DRAIN;
                        cand_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!inflight_c) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cand_valid_o      = cand_valid_q;
    assign cand_data_o       = cand_data_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign issued_count_o    = issued_q;
    assign sat_count_o       = sat_q;
    assign first_sat_found_o = found_q;
    assign first_sat_data_o  = found_data_q;

endmodule
